// File: rtl/sram_arbiter.sv
// sram_arbiter: fixed-priority arbiter for one external asynchronous SRAM.
// Each access runs SETUP -> STROBE (ACCESS_CYCLES) -> HOLD and every output
// is registered. Requester 0 has the highest priority.
// Optional feature: define SRAM_ARB_LOCK_EN to enable locked bursts via
// req_lock (HOLD -> SETUP back-to-back for the same requester).
module sram_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic                      sram_cen,
    output logic                      sram_oen,
    output logic                      sram_wen,
    output logic [DATA_W-1:0]         sram_wdata,
    output logic                      sram_data_oe,
    input  logic [DATA_W-1:0]         sram_rdata
);

    localparam int         IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    generate
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
            $fatal(1, "sram_arbiter: ACCESS_CYCLES must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IW-1:0]       win_q, win_d, pick, take_idx;
    logic                rnw_q, rnw_d, take;
    logic [NUM_REQ-1:0]  gnt_d, done_d;
    logic [DATA_W-1:0]   rdata_d, wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                cen_d, oen_d, wen_d, doe_d, busy_d;

`ifdef SRAM_ARB_LOCK_EN
    // Set when a locked requester had to leave a burst because its direction
    // changed; it then wins the following IDLE regardless of priority.
    logic prio_q, prio_d;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Lowest set req index wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) pick = IW'(i);
        end
    end

    // Next state, request capture and next registered pin/handshake values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        rnw_d    = rnw_q;
        rdata_d  = rdata;
        addr_d   = sram_addr;
        wdata_d  = sram_wdata;
        gnt_d    = '0;
        done_d   = '0;
        cen_d    = 1'b1;
        oen_d    = 1'b1;
        wen_d    = 1'b1;
        doe_d    = 1'b0;
        busy_d   = 1'b0;
        take     = 1'b0;
        take_idx = pick;
`ifdef SRAM_ARB_LOCK_EN
        prio_d   = prio_q;
`endif
        case (state_q)
            IDLE: begin
                take = |req;
`ifdef SRAM_ARB_LOCK_EN
                if (prio_q && req[win_q]) take_idx = win_q;
                prio_d = 1'b0;
`endif
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LOAD;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    if (rnw_q) rdata_d = sram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
`ifdef SRAM_ARB_LOCK_EN
                if (req_lock[win_q] && req[win_q]) begin
                    if (req_rnw[win_q] == rnw_q) begin
                        take     = 1'b1;
                        take_idx = win_q;
                    end else begin
                        prio_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = SETUP;
            win_d   = take_idx;
            rnw_d   = req_rnw[take_idx];
            addr_d  = req_addr[int'(take_idx)*ADDR_W +: ADDR_W];
            wdata_d = req_wdata[int'(take_idx)*DATA_W +: DATA_W];
        end

        case (state_d)
            SETUP: begin
                gnt_d[win_d] = 1'b1;
                busy_d = 1'b1;
                cen_d  = 1'b0;
                oen_d  = ~rnw_d;
                doe_d  = ~rnw_d;
            end
            STROBE: begin
                busy_d = 1'b1;
                cen_d  = 1'b0;
                oen_d  = ~rnw_d;
                wen_d  = rnw_d;
                doe_d  = ~rnw_d;
            end
            HOLD: begin
                done_d[win_d] = 1'b1;
                busy_d = 1'b1;
                cen_d  = 1'b0;
                doe_d  = ~rnw_d;
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_q        <= '0;
            rnw_q        <= 1'b0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_cen     <= 1'b1;
            sram_oen     <= 1'b1;
            sram_wen     <= 1'b1;
            sram_data_oe <= 1'b0;
`ifdef SRAM_ARB_LOCK_EN
            prio_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            rnw_q        <= rnw_d;
            gnt          <= gnt_d;
            done         <= done_d;
            rdata        <= rdata_d;
            busy         <= busy_d;
            sram_addr    <= addr_d;
            sram_wdata   <= wdata_d;
            sram_cen     <= cen_d;
            sram_oen     <= oen_d;
            sram_wen     <= wen_d;
            sram_data_oe <= doe_d;
`ifdef SRAM_ARB_LOCK_EN
            prio_q       <= prio_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table, hand sequences for contention,
// reset abort and locked bursts, then randomized traffic against a
// transaction-level timing model.
module tb_sram_arbiter;
    localparam int NR = 3, AW = 19, DW = 8, AC = 2;
    localparam int RN = 1500;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0] req, req_rnw, req_lock;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0] gnt, done;
    logic [DW-1:0] rdata, sram_wdata, sram_rdata;
    logic busy, sram_cen, sram_oen, sram_wen, sram_data_oe;
    logic [AW-1:0] sram_addr;

    int total = 0;
    int bad = 0;

    logic [7:0] pin_mem [16];
    logic [7:0] mm [16];

    logic [NR-1:0] eg [0:RN+7];
    logic [NR-1:0] ed [0:RN+7];
    logic          eb [0:RN+7];
    logic          ew [0:RN+7];
    logic          eo [0:RN+7];
    logic          rv [0:RN+7];
    logic [7:0]    rval [0:RN+7];

    typedef struct {
        int            r;
        logic          rnw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    sram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_lock(req_lock), .gnt(gnt), .done(done), .rdata(rdata),
        .busy(busy), .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_oen(sram_oen),
        .sram_wen(sram_wen), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
        .sram_rdata(sram_rdata)
    );

    // Pad-level SRAM model (address aliased to 4 bits).
    always @(posedge clk) begin
        if (!sram_cen && !sram_wen && sram_data_oe) pin_mem[sram_addr[3:0]] <= sram_wdata;
    end
    always @(negedge clk) begin
        sram_rdata <= (!sram_cen && !sram_oen) ? pin_mem[sram_addr[3:0]] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic rnw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = v;
        req_rnw[i] = rnw;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One isolated access; checks latencies and the pin waveform by cycle.
    task automatic xact(input vec_t v);
        int gc = -1;
        int dc = -1;
        logic [31:0] cen_o = '0, wen_o = '0, oen_o = '0, doe_o = '0;
        logic [31:0] cen_x = '0, wen_x = '0, oen_x = '0, doe_x = '0;
        logic [AW-1:0] a_setup = '0;
        drive(v.r, 1'b1, v.rnw, v.a, v.wd);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (gnt[v.r] && gc < 0) begin
                gc = c;
                a_setup = sram_addr;
                drive(v.r, 1'b0, 1'b0, '0, '0);
            end
            if (done[v.r] && dc < 0) dc = c;
            cen_o[c] = ~sram_cen;
            wen_o[c] = ~sram_wen;
            oen_o[c] = ~sram_oen;
            doe_o[c] = sram_data_oe;
        end
        drive(v.r, 1'b0, 1'b0, '0, '0);
        for (int c = 1; c <= 2 + AC; c++) begin
            cen_x[c] = 1'b1;
            if (!v.rnw) doe_x[c] = 1'b1;
        end
        for (int c = 2; c <= 1 + AC; c++) if (!v.rnw) wen_x[c] = 1'b1;
        for (int c = 1; c <= 1 + AC; c++) if (v.rnw) oen_x[c] = 1'b1;
        chk("gnt_latency", gc, 1);
        chk("done_latency", dc, 2 + AC);
        chk("setup_addr", a_setup, v.a);
        chk("cen_wave", cen_o, cen_x);
        chk("wen_wave", wen_o, wen_x);
        chk("oen_wave", oen_o, oen_x);
        chk("data_oe_wave", doe_o, doe_x);
        chk("rdata", rdata, v.exp_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g [NR];
        int multi, k, dcnt, g1, period, fa, w;
        int g0 [4];
        logic [NR-1:0] pend, gm;
        logic [7:0] exp_rd;

        tbl[0] = '{1, 1'b0, 19'h12345, 8'hA5, 8'h00};
        tbl[1] = '{1, 1'b1, 19'h12345, 8'h00, 8'hA5};
        tbl[2] = '{0, 1'b0, 19'h00000, 8'h3C, 8'hA5};
        tbl[3] = '{2, 1'b0, 19'h7FFFF, 8'hC3, 8'hA5};
        tbl[4] = '{2, 1'b1, 19'h7FFFF, 8'h00, 8'hC3};
        tbl[5] = '{0, 1'b1, 19'h00000, 8'h00, 8'h3C};
        tbl[6] = '{1, 1'b1, 19'h12345, 8'h00, 8'hA5};

        reset = 1'b1; req = '0; req_rnw = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_pins", {sram_cen, sram_oen, sram_wen, sram_data_oe}, 4'b1110);

        for (int i = 0; i < 7; i++) xact(tbl[i]);

        // Contention: all three in the same cycle, each held until granted.
        drive(0, 1'b1, 1'b0, 19'h1, 8'h11);
        drive(1, 1'b1, 1'b0, 19'h2, 8'h22);
        drive(2, 1'b1, 1'b0, 19'h3, 8'h33);
        for (int i = 0; i < NR; i++) g[i] = -1;
        multi = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if ($countones(gnt) > 1 || $countones(done) > 1) multi++;
            for (int i = 0; i < NR; i++) begin
                if (gnt[i] && g[i] < 0) begin
                    g[i] = c;
                    drive(i, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        chk("cont_gnt0", g[0], 1);
        chk("cont_gnt1", g[1], 1 + (3 + AC));
        chk("cont_gnt2", g[2], 1 + 2 * (3 + AC));
        chk("cont_onehot", multi, 0);

        // Reset in the middle of a write strobe.
        drive(2, 1'b1, 1'b0, 19'h5, 8'h77);
        tick();
        chk("rstab_gnt", gnt[2], 1);
        drive(2, 1'b0, 1'b0, '0, '0);
        tick();
        chk("rstab_in_strobe", sram_wen, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstab_pins", {sram_cen, sram_wen, sram_data_oe, busy}, 4'b1100);
        chk("rstab_rdata", rdata, 0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done != '0) dcnt++;
            tick();
        end
        chk("rstab_no_done", dcnt, 0);
        xact('{1, 1'b1, 19'h7FFFF, 8'h00, 8'hC3});

        // Locked read burst from requester 0 while requester 1 waits.
`ifdef SRAM_ARB_LOCK_EN
        period = 2 + AC;
`else
        period = 3 + AC;
`endif
        req_lock[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 19'h0, 8'h00);
        drive(1, 1'b1, 1'b0, 19'h6, 8'h5A);
        k = 0; dcnt = 0; g1 = -1;
        for (int i = 0; i < 4; i++) g0[i] = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done[0]) dcnt++;
            if (gnt[1] && g1 < 0) begin
                g1 = c;
                drive(1, 1'b0, 1'b0, '0, '0);
            end
            if (gnt[0] && k < 4) begin
                g0[k] = c;
                k++;
                if (k < 4) drive(0, 1'b1, 1'b1, AW'(k), 8'h00);
                else begin
                    drive(0, 1'b0, 1'b0, '0, '0);
                    req_lock[0] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) chk("lock_gnt0", g0[i], 1 + i * period);
        chk("lock_done0", dcnt, 4);
        chk("lock_gnt1", g1, 1 + 3 * period + 3 + AC);

        // Randomized traffic against a transaction-level timing model.
        reset = 1'b1;
        req = '0; req_lock = '0;
        for (int i = 0; i < 16; i++) begin
            mm[i] = 8'($urandom);
            pin_mem[i] = mm[i];
        end
        for (int c = 0; c <= RN + 7; c++) begin
            eg[c] = '0; ed[c] = '0; eb[c] = 0; ew[c] = 0; eo[c] = 0; rv[c] = 0; rval[c] = '0;
        end
        tick(); tick();
        reset = 1'b0;
        fa = 0; pend = '0; gm = '0; exp_rd = 8'h00;
        for (int kc = 0; kc < RN; kc++) begin
            for (int i = 0; i < NR; i++) begin
                if (gm[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    drive(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 8'($urandom));
                end
                req[i] = pend[i];
            end
            gm = '0;
            if (kc >= fa && req != '0) begin
                w = 0;
                for (int i = NR - 1; i >= 0; i--) if (req[i]) w = i;
                eg[kc + 1][w] = 1'b1;
                ed[kc + 2 + AC][w] = 1'b1;
                for (int c = kc + 1; c <= kc + 2 + AC; c++) eb[c] = 1'b1;
                if (req_rnw[w]) begin
                    rv[kc + 2 + AC] = 1'b1;
                    rval[kc + 2 + AC] = mm[req_addr[w*AW +: 4]];
                end else begin
                    mm[req_addr[w*AW +: 4]] = req_wdata[w*DW +: DW];
                    for (int c = kc + 2; c <= kc + 1 + AC; c++) ew[c] = 1'b1;
                    for (int c = kc + 1; c <= kc + 2 + AC; c++) eo[c] = 1'b1;
                end
                fa = kc + 3 + AC;
                gm[w] = 1'b1;
            end
            tick();
            if (rv[kc + 1]) exp_rd = rval[kc + 1];
            chk("rnd_gnt", gnt, eg[kc + 1]);
            chk("rnd_done", done, ed[kc + 1]);
            chk("rnd_busy", busy, eb[kc + 1]);
            chk("rnd_cen", sram_cen, !eb[kc + 1]);
            chk("rnd_wen", sram_wen, !ew[kc + 1]);
            chk("rnd_data_oe", sram_data_oe, eo[kc + 1]);
            chk("rnd_rdata", rdata, exp_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single external asynchronous SRAM (19-bit address, 8-bit data) between NUM_REQ requesters: pattern generator (index 0), SCARF ext-SRAM slave (1), edge-capture logger (2).
- Sequences each access through setup, strobe and hold phases; drives the SRAM pins and the data tristate enable.
- Returns read data with a completion pulse.
- Sits between the SCARF slaves and the top-level SRAM pins, replacing ad-hoc pin muxing.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has highest fixed priority.
- ADDR_W, 19, SRAM address width.
- DATA_W, 8, SRAM data width.
- ACCESS_CYCLES, 2, strobe length in clk cycles; legal 1..15.

Ports:
- clk  input  1  fpga board clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester access request.
- req_rnw  input  NUM_REQ  per-requester 1=read, 0=write.
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data.
- req_lock  input  NUM_REQ  burst lock (SRAM_ARB_LOCK_EN only; ignored otherwise).
- gnt  output  NUM_REQ  one-cycle pulse: request accepted and captured.
- done  output  NUM_REQ  one-cycle pulse: access complete; rdata valid if read.
- rdata  output  DATA_W  captured read data; holds until next read completes.
- busy  output  1  high in any state except IDLE.
- sram_addr  output  ADDR_W  SRAM address.
- sram_cen  output  1  chip enable, active low.
- sram_oen  output  1  output enable, active low.
- sram_wen  output  1  write enable, active low.
- sram_wdata  output  DATA_W  write data to pad.
- sram_data_oe  output  1  1 = FPGA drives the data pad.
- sram_rdata  input  DATA_W  data from pad.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdata=0, busy=0, sram_addr=0, sram_wdata=0, sram_cen=1, sram_oen=1, sram_wen=1, sram_data_oe=0; state IDLE; strobe counter 0.
- Reset mid-access aborts immediately: no done pulse, pins return to the reset values on the next edge.
- States:
  - IDLE: all controls inactive. If any req bit is high, the winner w is the lowest index with req set. Latch req_addr[w], req_rnw[w], req_wdata[w]. Go to SETUP.
  - SETUP (1 cycle): gnt[w]=1. sram_addr valid, sram_cen=0. Read: sram_oen=0, sram_data_oe=0. Write: sram_data_oe=1, sram_wen=1.
  - STROBE (ACCESS_CYCLES cycles, 4-bit down-counter): write asserts sram_wen=0; read keeps sram_oen=0. On the last STROBE cycle, sram_rdata is registered into rdata (reads only).
  - HOLD (1 cycle): sram_wen=1, sram_oen=1, sram_cen=0, addr held. sram_data_oe stays 1 for writes to meet hold time. done[w]=1. Next state is IDLE.
- Latency: req first seen in IDLE at cycle T -> gnt at T+1 -> done at T+2+ACCESS_CYCLES.
- Minimum access period is 3+ACCESS_CYCLES cycles. The mandatory IDLE cycle provides bus turnaround between any read and a following write.
- Handshake:
  - Requester holds req, rnw, addr and wdata stable until it sees gnt.
  - After gnt, inputs may change; the latched copy is used.
  - req is sampled only in IDLE; a req asserted in another state waits.
  - req dropped before gnt means the request is withdrawn (legal) and no gnt is issued.
- Simultaneous requests: fixed priority, 0 > 1 > 2. A loser keeps req high and is served in a later IDLE; starvation of low indices is acceptable by design.
- gnt and done are each one-hot or zero; never two bits at once.
- rdata is unchanged on write completions.
- busy=1 in SETUP, STROBE and HOLD.
- ACCESS_CYCLES outside 1..15 is a fatal elaboration error.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- With the macro:
  - In HOLD, if req_lock[w] and req[w] are both high and req_rnw[w] equals the latched rnw, HOLD goes directly to SETUP for the same w. The new inputs are latched and gnt pulses again, giving a burst period of 2+ACCESS_CYCLES.
  - If rnw differs, HOLD goes to IDLE, and w wins IDLE regardless of priority.
  - Lock is released when req_lock[w] drops at a HOLD evaluation.
- Without the macro: req_lock is ignored, HOLD always goes to IDLE, and pure fixed priority applies.

Test Plan:
- Single write, ACCESS_CYCLES=2: req[1]=1, addr=0x12345, wdata=0xA5 at T.
  - gnt[1] at T+1; sram_wen=0 at T+2..T+3; done[1] at T+4.
  - sram_data_oe=1 at T+1..T+4; sram_cen=1 again at T+5.
- Read-back: req[1], rnw=1, addr=0x12345, model returns 0xA5.
  - sram_oen=0 for SETUP+STROBE; done[1] at T+4 with rdata=0xA5; sram_data_oe stays 0 throughout.
- Contention: req=3'b111 in the same cycle, each held until its gnt.
  - Grants in order 0, 1, 2; each pair of accesses separated by one IDLE cycle; never two gnt bits high together.
- Reset mid-strobe: assert reset during the STROBE of a write.
  - Next cycle: sram_cen=1, sram_wen=1, sram_data_oe=0; no done pulse; the next request completes normally.
- Lock burst (SRAM_ARB_LOCK_EN): requester 0 issues 4 locked reads at 0x00000..0x00003 while req[1] is high.
  - 4 consecutive gnt[0]/done[0] pulses with a 4-cycle period; requester 1 is granted only after the lock drops.
  - Without the macro, the same stimulus inserts an IDLE cycle between reads, but requester 0 still keeps winning on priority.
- ACCESS_CYCLES=1 and 15 builds: done arrives exactly 3 and 17 cycles after the IDLE cycle in which req is first seen.
